fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 186 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns PCF, issues single-outstanding fetches to
// instruction memory and presents the IF/ID pipeline register to decode.
// A one-entry hold buffer parks a returned word while decode is stalled.
// Redirects that race an outstanding fetch mark it killed so its late
// response is dropped.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2
  } fetchStateT;

  fetchStateT      stateQ;
  fetchStateT      stateNext;
  logic            killQ;
  logic            killNext;
  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] pcNext;
  logic [XLEN-1:0] pcPlus4F;
  logic [XLEN-1:0] holdInstr;
  logic            respLive;
  logic            deliver;
  logic            holdCapture;
  logic [XLEN-1:0] deliverInstr;

  // Sequential successor of the current fetch PC, wraps modulo 2^32
  assign pcPlus4F  = pcF + XLEN'(4);
  assign imem_addr = pcF;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= StReq;
    end else begin
      stateQ <= stateNext;
    end
  end

  // FSM next-state and kill-flag logic
  always_comb begin
    stateNext = stateQ;
    killNext  = killQ;
    case (stateQ)
      StReq: begin
        stateNext = StWait;
        if (PCSrcE) begin
          killNext = 1'b1;
        end
      end
      StWait: begin
        if (imem_valid) begin
          if (killQ) begin
            killNext  = 1'b0;
            stateNext = StReq;
          end else if (PCSrcE) begin
            stateNext = StReq;
          end else if (StallF) begin
            stateNext = StHold;
          end else begin
            stateNext = StReq;
          end
        end else if (PCSrcE) begin
          killNext = 1'b1;
        end
      end
      StHold: begin
        if (PCSrcE || !StallF) begin
          stateNext = StReq;
        end
      end
      default: begin
        stateNext = StReq;
        killNext  = 1'b0;
      end
    endcase
  end

  // FSM outputs: request strobe, delivery to IF/ID and hold-buffer capture
  always_comb begin
    imem_req     = 1'b0;
    deliver      = 1'b0;
    holdCapture  = 1'b0;
    deliverInstr = imem_rdata;
    respLive     = imem_valid && !killQ && !PCSrcE;
    case (stateQ)
      StReq: begin
        // State already reads REQ during reset, so the strobe is gated here
        imem_req = rst;
      end
      StWait: begin
        if (respLive) begin
          if (StallF) begin
            holdCapture = 1'b1;
          end else begin
            deliver = 1'b1;
          end
        end
      end
      StHold: begin
        if (!PCSrcE && !StallF) begin
          deliver      = 1'b1;
          deliverInstr = holdInstr;
        end
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  // Next PC: redirect wins over everything, otherwise advance on delivery.
  // A delivery that decode flushes still retires the fetch, so PC advances.
  always_comb begin
    pcNext = pcF;
    if (PCSrcE) begin
      pcNext = PCTargetE;
    end else if (deliver) begin
      pcNext = pcPlus4F;
    end
  end

  // Fetch PC and kill flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcF   <= RESET_PC;
      killQ <= 1'b0;
    end else begin
      pcF   <= pcNext;
      killQ <= killNext;
    end
  end

  // One-entry hold buffer for a word returned while decode is stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      holdInstr <= '0;
    end else if (holdCapture) begin
      holdInstr <= imem_rdata;
    end
  end

  // IF/ID pipeline register: flush bubble, stall freeze, load or bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!StallF) begin
      if (deliver) begin
        InstrD   <= deliverInstr;
        PCD      <= pcF;
        PCPlus4D <= pcPlus4F;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a
// stream-level model (instructions must arrive in program order, each word
// matching memory at its PC, with redirects restarting the stream).
module tb_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, FlushD, PCSrcE, imem_valid;
  logic [31:0] PCTargetE, imem_rdata;
  logic        imem_req, ValidD;
  logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;
  logic        wReq, wValid;
  logic [31:0] wAddr, wInstr, wPcd, wPc4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(Nop)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .InstrD(InstrD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(Nop)) dutWrap (
    .clk(clk), .rst(rst), .StallF(StallF), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(wReq), .imem_addr(wAddr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .InstrD(wInstr),
    .PCD(wPcd), .PCPlus4D(wPc4), .ValidD(wValid)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0A93;
  endfunction

  task automatic doReset();
    rst = 1'b0; StallF = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = '0; imem_valid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; StallF = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = '0; imem_valid = 1'b0; imem_rdata = '0;
    #2 rst = 1'b0;
    step();
    total++;
    if ({imem_req, imem_addr, InstrD, PCD, PCPlus4D, ValidD} !==
        {1'b0, 32'h0, Nop, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b addr=%h instr=%h pcd=%h pc4=%h v=%b want 0/0/%h/0/0/0",
               imem_req, imem_addr, InstrD, PCD, PCPlus4D, ValidD, Nop);
    end
    total++;
    if (wReq !== 1'b0 || wAddr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL reset_wrap_pc: got req=%b addr=%h want 0/fffffffc", wReq, wAddr);
    end
    rst = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_first_req: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_basic_fetch();
    doReset();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL basic_req0: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    end
    step();
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL basic_wait_noreq: got req=%b want 0", imem_req);
    end
    imem_valid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_valid = 1'b0; imem_rdata = 32'h1234_5678;
    total++;
    if ({InstrD, PCD, PCPlus4D, ValidD} !== {32'h0050_0093, 32'h0, 32'h4, 1'b1}) begin
      bad++;
      $display("FAIL basic_ifid: got instr=%h pcd=%h pc4=%h v=%b want 00500093/0/4/1",
               InstrD, PCD, PCPlus4D, ValidD);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      bad++;
      $display("FAIL basic_req4: got req=%b addr=%h want 1/00000004", imem_req, imem_addr);
    end
    total++;
    if ({wInstr, wPcd, wPc4, wValid, wReq, wAddr} !==
        {32'h0050_0093, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL wrap_fetch: got instr=%h pcd=%h pc4=%h v=%b req=%b addr=%h want 00500093/fffffffc/0/1/1/0",
               wInstr, wPcd, wPc4, wValid, wReq, wAddr);
    end
  endtask

  task automatic test_stall_hold();
    doReset();
    StallF = 1'b1;
    step();
    imem_valid = 1'b1; imem_rdata = 32'h00A0_0113;
    step();
    imem_valid = 1'b0; imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({InstrD, PCD, PCPlus4D, ValidD, imem_req, imem_addr} !==
          {Nop, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
        bad++;
        $display("FAIL stall_frozen[%0d]: got instr=%h pcd=%h pc4=%h v=%b req=%b addr=%h want nop/0/0/0/0/0",
                 i, InstrD, PCD, PCPlus4D, ValidD, imem_req, imem_addr);
      end
      if (i < 2) step();
    end
    StallF = 1'b0;
    step();
    total++;
    if ({InstrD, PCD, PCPlus4D, ValidD, imem_req, imem_addr} !==
        {32'h00A0_0113, 32'h0, 32'h4, 1'b1, 1'b1, 32'h4}) begin
      bad++;
      $display("FAIL stall_release: got instr=%h pcd=%h pc4=%h v=%b req=%b addr=%h want 00a00113/0/4/1/1/4",
               InstrD, PCD, PCPlus4D, ValidD, imem_req, imem_addr);
    end
    step();
    total++;
    if ({InstrD, PCD, ValidD} !== {Nop, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL stall_once: got instr=%h pcd=%h v=%b want nop/0/0", InstrD, PCD, ValidD);
    end
  endtask

  task automatic test_redirect_kill();
    doReset();
    step();
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    step();
    PCSrcE = 1'b0; PCTargetE = 32'h0;
    total++;
    if (imem_addr !== 32'h100 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL kill_wait: got addr=%h req=%b want 00000100/0", imem_addr, imem_req);
    end
    step();
    imem_valid = 1'b1; imem_rdata = 32'h0FF0_0FF3;
    step();
    imem_valid = 1'b0;
    total++;
    if ({ValidD, InstrD, imem_req, imem_addr} !== {1'b0, Nop, 1'b1, 32'h100}) begin
      bad++;
      $display("FAIL kill_discard: got v=%b instr=%h req=%b addr=%h want 0/nop/1/100",
               ValidD, InstrD, imem_req, imem_addr);
    end
    step();
    imem_valid = 1'b1; imem_rdata = 32'h00C0_0193;
    step();
    imem_valid = 1'b0;
    total++;
    if ({InstrD, PCD, PCPlus4D, ValidD} !== {32'h00C0_0193, 32'h100, 32'h104, 1'b1}) begin
      bad++;
      $display("FAIL kill_refetch: got instr=%h pcd=%h pc4=%h v=%b want 00c00193/100/104/1",
               InstrD, PCD, PCPlus4D, ValidD);
    end
  endtask

  task automatic test_flush_stall();
    doReset();
    step();
    imem_valid = 1'b1; imem_rdata = 32'h0010_0093;
    step();
    imem_valid = 1'b0;
    total++;
    if (ValidD !== 1'b1) begin
      bad++;
      $display("FAIL flush_pre: got v=%b want 1", ValidD);
    end
    StallF = 1'b1; FlushD = 1'b1;
    step();
    StallF = 1'b0; FlushD = 1'b0;
    total++;
    if ({InstrD, PCD, PCPlus4D, ValidD} !== {32'h0000_0013, 32'h0, 32'h4, 1'b0}) begin
      bad++;
      $display("FAIL flush_stall: got instr=%h pcd=%h pc4=%h v=%b want 00000013/0/4/0",
               InstrD, PCD, PCPlus4D, ValidD);
    end
  endtask

  task automatic test_reset_mid_wait();
    doReset();
    step();
    imem_valid = 1'b1; imem_rdata = 32'h0020_0093;
    step();
    imem_valid = 1'b0;
    step();
    total++;
    if (imem_addr !== 32'h4 || ValidD !== 1'b0 || PCD !== 32'h0) begin
      bad++;
      $display("FAIL midrst_pre: got addr=%h v=%b pcd=%h want 4/0/0", imem_addr, ValidD, PCD);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({imem_req, imem_addr, InstrD, PCD, PCPlus4D, ValidD} !==
        {1'b0, 32'h0, Nop, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_async: got req=%b addr=%h instr=%h pcd=%h pc4=%h v=%b want 0/0/nop/0/0/0",
               imem_req, imem_addr, InstrD, PCD, PCPlus4D, ValidD);
    end
    @(negedge clk);
    rst = 1'b1; imem_valid = 1'b1; imem_rdata = 32'h0BAD_0093;
    #1;
    step();
    imem_valid = 1'b0;
    total++;
    if ({ValidD, InstrD, imem_req, imem_addr} !== {1'b0, Nop, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL midrst_stale: got v=%b instr=%h req=%b addr=%h want 0/nop/0/0",
               ValidD, InstrD, imem_req, imem_addr);
    end
    imem_valid = 1'b1; imem_rdata = 32'h0030_0093;
    step();
    imem_valid = 1'b0;
    total++;
    if ({InstrD, PCD, ValidD} !== {32'h0030_0093, 32'h0, 1'b1}) begin
      bad++;
      $display("FAIL midrst_fresh: got instr=%h pcd=%h v=%b want 00300093/0/1", InstrD, PCD, ValidD);
    end
  endtask

  task automatic test_random();
    logic [31:0] expPc, mInstr, mPcd, mPc4, pTarget, pendAddr;
    logic        mValid, pStall, pFlush, pSrc, pending;
    int          pendCnt, deliveries;
    doReset();
    expPc = '0; mInstr = Nop; mPcd = '0; mPc4 = '0; mValid = 1'b0;
    pStall = 1'b1; pFlush = 1'b0; pSrc = 1'b0; pTarget = '0;
    pending = 1'b0; pendAddr = '0; pendCnt = 0; deliveries = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Expected IF/ID after the edge just taken
      if (pFlush) begin
        mInstr = Nop; mValid = 1'b0;
      end else if (!pStall) begin
        if (ValidD === 1'b1) begin
          total++;
          if (pSrc) begin
            bad++;
            $display("FAIL rand_redirect_delivery: cyc=%0d got delivery pcd=%h want none", cyc, PCD);
          end
          mInstr = memWord(expPc); mPcd = expPc; mPc4 = expPc + 32'd4; mValid = 1'b1;
          expPc = expPc + 32'd4;
          deliveries++;
        end else begin
          mInstr = Nop; mValid = 1'b0;
        end
      end
      total++;
      if ({InstrD, PCD, PCPlus4D, ValidD} !== {mInstr, mPcd, mPc4, mValid}) begin
        bad++;
        $display("FAIL rand_ifid: cyc=%0d got instr=%h pcd=%h pc4=%h v=%b want %h/%h/%h/%b",
                 cyc, InstrD, PCD, PCPlus4D, ValidD, mInstr, mPcd, mPc4, mValid);
      end
      if (pSrc) expPc = pTarget;
      // Memory: one response per request after 1..3 cycles
      imem_valid = 1'b0;
      imem_rdata = $urandom();
      if (pending) begin
        pendCnt--;
        if (pendCnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = memWord(pendAddr);
          pending = 1'b0;
        end
      end
      if (imem_req === 1'b1) begin
        total++;
        if (imem_addr !== expPc || pending) begin
          bad++;
          $display("FAIL rand_req: cyc=%0d got addr=%h outstanding=%b want %h/0",
                   cyc, imem_addr, pending, expPc);
        end
        pending = 1'b1;
        pendAddr = imem_addr;
        pendCnt = int'($urandom_range(1, 3));
      end
      pStall  = ($urandom_range(0, 3) == 0);
      pSrc    = ($urandom_range(0, 24) == 0);
      pFlush  = pSrc && ($urandom_range(0, 1) == 1);
      pTarget = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_FFFC);
      StallF = pStall; FlushD = pFlush; PCSrcE = pSrc; PCTargetE = pTarget;
      step();
    end
    StallF = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; imem_valid = 1'b0;
    total++;
    if (deliveries < 200) begin
      bad++;
      $display("FAIL rand_liveness: got deliveries=%0d want >=200", deliveries);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_redirect_kill();
    test_flush_stall();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
